// File: rtl/jt6295_pkg.sv
// Shared definitions for the JT6295 command controller: FSM state encoding,
// phrase-table geometry and issue-window length.
package jt6295_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_FETCH = 3'd2,
        ST_SYNC  = 3'd3,
        ST_ISSUE = 3'd4
    } state_t;

    // Each phrase owns an 8-byte slot in the table; only the first 6 bytes are used.
    localparam int TBL_STRIDE = 8;
    localparam int TBL_BYTES  = 6;
    localparam int IDX_W      = $clog2(TBL_STRIDE);

    // Start/stop stay asserted for four channel slots (down-counter 3..0).
    localparam logic [1:0] ISSUE_LAST = 2'd3;

endpackage

// File: rtl/jt6295_phrase_fetch.sv
// Phrase-table byte sequencer: reads the 6 table bytes of a phrase, one
// rom_cs/rom_ok handshake per byte, and assembles the start/stop addresses.
// rom_cs is released for one clock between bytes so a lingering rom_ok from the
// previous byte cannot be taken as the next one.
module jt6295_phrase_fetch
    import jt6295_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go_i,
    input  logic [6:0]  phrase_i,
    output logic [17:0] rom_addr_o,
    output logic        rom_cs_o,
    input  logic [7:0]  rom_data_i,
    input  logic        rom_ok_i,
    output logic [17:0] start_addr_o,
    output logic [17:0] stop_addr_o,
    output logic        done_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TBL_BYTES - 1);

    logic             active_q;
    logic             cs_q;
    logic             done_q;
    logic [IDX_W-1:0] idx_q;
    logic [17:0]      start_q;
    logic [17:0]      stop_q;

    // Byte sequencer, handshake and address assembly (upper 6 bits of b0/b3 dropped).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cs_q     <= 1'b0;
            done_q   <= 1'b0;
            idx_q    <= '0;
            start_q  <= '0;
            stop_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (go_i) begin
                active_q <= 1'b1;
                cs_q     <= 1'b1;
                idx_q    <= '0;
            end else if (active_q) begin
                if (!cs_q) begin
                    cs_q <= 1'b1;
                end else if (rom_ok_i) begin
                    cs_q <= 1'b0;
                    case (idx_q)
                        3'd0:    start_q[17:16] <= rom_data_i[1:0];
                        3'd1:    start_q[15:8]  <= rom_data_i;
                        3'd2:    start_q[7:0]   <= rom_data_i;
                        3'd3:    stop_q[17:16]  <= rom_data_i[1:0];
                        3'd4:    stop_q[15:8]   <= rom_data_i;
                        3'd5:    stop_q[7:0]    <= rom_data_i;
                        default: ;
                    endcase
                    if (idx_q == LAST_IDX) begin
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
            end
        end
    end

    assign rom_addr_o   = {8'd0, phrase_i, idx_q};
    assign rom_cs_o     = cs_q;
    assign start_addr_o = start_q;
    assign stop_addr_o  = stop_q;
    assign done_o       = done_q;

endmodule

// File: rtl/jt6295_cmd_ctrl.sv
// JT6295 CPU command controller: decodes the two-byte start command and the
// one-byte stop command, fetches phrase addresses and issues per-channel
// start/stop pulses aligned to the channel-0 slot.
// Build option: JT6295_BUSYCHK_EN -- when defined, channels already busy at the
// SYNC->ISSUE transition are not restarted.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a command byte
// ST_ARMED | phrase latched, waiting for the mask/attenuation byte
// ST_FETCH | reading the 6 phrase-table bytes
// ST_SYNC  | waiting for the channel-0 slot (cen4 & zero)
// ST_ISSUE | start or stop held for 4 channel slots
module jt6295_cmd_ctrl
    import jt6295_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen4,
    input  logic        zero,
    input  logic        wr,
    input  logic [7:0]  din,
    input  logic [3:0]  busy,
    output logic [17:0] rom_addr,
    output logic        rom_cs,
    input  logic [7:0]  rom_data,
    input  logic        rom_ok,
    output logic [17:0] start_addr,
    output logic [17:0] stop_addr,
    output logic [3:0]  att,
    output logic [3:0]  start,
    output logic [3:0]  stop,
    output logic        ctrl_busy,
    output logic        drop
);

    state_t     state_q, state_d;
    logic [6:0] phrase_q, phrase_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] att_q, att_d;
    logic       is_stop_q, is_stop_d;
    logic [1:0] cnt_q, cnt_d;
    logic       fetch_go;
    logic       fetch_done;

`ifndef JT6295_BUSYCHK_EN
    logic unused_busy;
    assign unused_busy = ^busy;
`endif

    // State and command registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            phrase_q  <= '0;
            mask_q    <= '0;
            att_q     <= '0;
            is_stop_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            phrase_q  <= phrase_d;
            mask_q    <= mask_d;
            att_q     <= att_d;
            is_stop_q <= is_stop_d;
            cnt_q     <= cnt_d;
        end
    end

    // Command decode and sequencing; writes outside IDLE/ARMED fall through untouched.
    always_comb begin
        state_d   = state_q;
        phrase_d  = phrase_q;
        mask_d    = mask_q;
        att_d     = att_q;
        is_stop_d = is_stop_q;
        cnt_d     = cnt_q;
        fetch_go  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr) begin
                    if (din[7]) begin
                        phrase_d = din[6:0];
                        state_d  = ST_ARMED;
                    end else begin
                        mask_d    = din[6:3];
                        is_stop_d = 1'b1;
                        state_d   = ST_SYNC;
                    end
                end
            end
            ST_ARMED: begin
                if (wr) begin
                    if (din[7:4] == 4'd0 || phrase_q == 7'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        mask_d    = din[7:4];
                        att_d     = din[3:0];
                        is_stop_d = 1'b0;
                        fetch_go  = 1'b1;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (fetch_done) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (cen4 && zero) begin
                    state_d = ST_ISSUE;
                    cnt_d   = ISSUE_LAST;
`ifdef JT6295_BUSYCHK_EN
                    if (!is_stop_q) mask_d = mask_q & ~busy;
`endif
                end
            end
            ST_ISSUE: begin
                if (cen4) begin
                    if (cnt_q == 2'd0) state_d = ST_IDLE;
                    else               cnt_d   = cnt_q - 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    jt6295_phrase_fetch u_fetch (
        .clk          (clk),
        .rst_n        (rst_n),
        .go_i         (fetch_go),
        .phrase_i     (phrase_q),
        .rom_addr_o   (rom_addr),
        .rom_cs_o     (rom_cs),
        .rom_data_i   (rom_data),
        .rom_ok_i     (rom_ok),
        .start_addr_o (start_addr),
        .stop_addr_o  (stop_addr),
        .done_o       (fetch_done)
    );

    assign ctrl_busy = (state_q == ST_FETCH) || (state_q == ST_SYNC) || (state_q == ST_ISSUE);
    assign drop      = wr && ctrl_busy;
    assign att       = att_q;
    assign start     = (state_q == ST_ISSUE && !is_stop_q) ? mask_q : 4'd0;
    assign stop      = (state_q == ST_ISSUE &&  is_stop_q) ? mask_q : 4'd0;

endmodule

// File: tb/tb_jt6295_cmd_ctrl.sv
// Directed bench for jt6295_cmd_ctrl: start/stop issue, busy check option,
// dropped writes, aborted commands and reset during a fetch.
module tb_jt6295_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen4 = 1'b0;
    logic        zero = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  din = 8'd0;
    logic [3:0]  busy = 4'd0;
    logic [17:0] rom_addr;
    logic        rom_cs;
    logic [7:0]  rom_data = 8'd0;
    logic        rom_ok = 1'b0;
    logic [17:0] start_addr;
    logic [17:0] stop_addr;
    logic [3:0]  att;
    logic [3:0]  start;
    logic [3:0]  stop;
    logic        ctrl_busy;
    logic        drop;

    int err_cnt = 0;
    int chk_cnt = 0;
    int rom_delay = 0;
    int cs_cycles = 0;
    logic last_cen_zero = 1'b0;
    logic [7:0] rom_mem [0:255];

    jt6295_cmd_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen4       (cen4),
        .zero       (zero),
        .wr         (wr),
        .din        (din),
        .busy       (busy),
        .rom_addr   (rom_addr),
        .rom_cs     (rom_cs),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .start_addr (start_addr),
        .stop_addr  (stop_addr),
        .att        (att),
        .start      (start),
        .stop       (stop),
        .ctrl_busy  (ctrl_busy),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    // cen4 every 4 clocks, zero on every 4th cen4.
    initial begin
        int cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            cen4 = (cyc % 4 == 0);
            zero = cen4 && (cyc % 16 == 0);
            if (cen4) last_cen_zero = zero;
        end
    end

    // ROM model: answers a held rom_cs after rom_delay clocks with a one-clock rom_ok.
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rom_cs) cs_cycles = cs_cycles + 1;
            if (rom_ok) begin
                rom_ok = 1'b0;
                cnt = 0;
            end else if (rom_cs) begin
                if (cnt >= rom_delay) begin
                    rom_ok = 1'b1;
                    rom_data = rom_mem[rom_addr[7:0]];
                end else begin
                    cnt = cnt + 1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (got !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr_cmd(input logic [7:0] d);
        @(posedge clk);
        #1;
        wr = 1'b1;
        din = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    // Waits for the issue window, checks its values, zero alignment and length.
    task automatic issue_check(input string tag, input logic [3:0] exp_start,
                               input logic [3:0] exp_stop, input bit drop_at_exit);
        int guard = 0;
        int n = 0;
        logic found = 1'b0;
        logic bad = 1'b0;
        logic drop_seen = 1'b0;
        while (!found && guard < 400) begin
            @(negedge clk);
            guard = guard + 1;
            if ((start | stop) != 4'd0) found = 1'b1;
        end
        chk({tag, " onset"}, 32'(found), 32'd1);
        if (found) begin
            chk({tag, " zero_align"}, 32'(last_cen_zero), 32'd1);
            chk({tag, " start"}, 32'(start), 32'(exp_start));
            chk({tag, " stop"}, 32'(stop), 32'(exp_stop));
            guard = 0;
            while ((start | stop) != 4'd0 && guard < 100) begin
                guard = guard + 1;
                if (start != exp_start || stop != exp_stop) bad = 1'b1;
                if (cen4) begin
                    n = n + 1;
                    if (drop_at_exit && n == 4) begin
                        wr = 1'b1;
                        din = 8'h30;
                        #1;
                        drop_seen = drop;
                        @(posedge clk);
                        #1;
                        wr = 1'b0;
                    end
                end
                @(negedge clk);
            end
            chk({tag, " slots"}, 32'(n), 32'd4);
            chk({tag, " stable"}, 32'(bad), 32'd0);
            if (drop_at_exit) begin
                chk({tag, " exit_drop"}, 32'(drop_seen), 32'd1);
                repeat (3) @(negedge clk);
                chk({tag, " exit_wr_ignored"}, 32'(ctrl_busy), 32'd0);
            end
        end
    endtask

    task automatic watch_no_start(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (start != 4'd0) seen = seen + 1;
        end
        chk({tag, " no_start"}, 32'(seen), 32'd0);
        chk({tag, " idle"}, 32'(ctrl_busy), 32'd0);
    endtask

    initial begin
        int cs0;
        int guard;
        logic hit;
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'h00;
        // phrase 5 at 0x28
        rom_mem[8'h28] = 8'h00; rom_mem[8'h29] = 8'h01; rom_mem[8'h2A] = 8'h00;
        rom_mem[8'h2B] = 8'h00; rom_mem[8'h2C] = 8'h02; rom_mem[8'h2D] = 8'h00;
        // phrase 3 at 0x18 (upper bits of b0/b3 set to prove they are ignored)
        rom_mem[8'h18] = 8'hFF; rom_mem[8'h19] = 8'h12; rom_mem[8'h1A] = 8'h34;
        rom_mem[8'h1B] = 8'hFD; rom_mem[8'h1C] = 8'h56; rom_mem[8'h1D] = 8'h78;

        repeat (3) @(negedge clk);
        chk("rst rom_cs", 32'(rom_cs), 32'd0);
        chk("rst outputs", {start, stop, att, 3'd0, ctrl_busy, drop}, 32'd0);
        chk("rst start_addr", 32'(start_addr), 32'd0);
        rst_n = 1'b1;

        // Start: phrase 5, mask 0001, att 2; write at the exit cycle is dropped.
        cs0 = cs_cycles;
        wr_cmd(8'h85);
        @(negedge clk);
        chk("armed not busy", 32'(ctrl_busy), 32'd0);
        wr_cmd(8'h12);
        @(negedge clk);
        chk("fetch busy", 32'(ctrl_busy), 32'd1);
        issue_check("start p5", 4'b0001, 4'b0000, 1'b1);
        chk("p5 start_addr", 32'(start_addr), 32'h00100);
        chk("p5 stop_addr", 32'(stop_addr), 32'h00200);
        chk("p5 att", 32'(att), 32'd2);

        // Stop: mask 0110, no ROM traffic.
        cs0 = cs_cycles;
        wr_cmd(8'h30);
        issue_check("stop", 4'b0000, 4'b0110, 1'b0);
        chk("stop rom_cs cycles", 32'(cs_cycles - cs0), 32'd0);

        // Busy check.
        busy = 4'b0011;
        wr_cmd(8'h85);
        wr_cmd(8'hF3);
`ifdef JT6295_BUSYCHK_EN
        issue_check("busychk", 4'b1100, 4'b0000, 1'b0);
`else
        issue_check("busychk", 4'b1111, 4'b0000, 1'b0);
`endif
        chk("busychk att", 32'(att), 32'd3);
        busy = 4'b0000;

        // Phrase 0 and zero mask are aborted.
        cs0 = cs_cycles;
        wr_cmd(8'h80);
        wr_cmd(8'h1F);
        watch_no_start("phrase0", 40);
        chk("phrase0 rom_cs cycles", 32'(cs_cycles - cs0), 32'd0);
        cs0 = cs_cycles;
        wr_cmd(8'h85);
        wr_cmd(8'h0F);
        watch_no_start("mask0", 40);
        chk("mask0 rom_cs cycles", 32'(cs_cycles - cs0), 32'd0);
        wr_cmd(8'h30);
        issue_check("after mask0 stop", 4'b0000, 4'b0110, 1'b0);

        // Dropped write during a slow fetch.
        rom_delay = 5;
        wr_cmd(8'h83);
        wr_cmd(8'h4A);
        repeat (3) @(posedge clk);
        #1;
        wr = 1'b1;
        din = 8'h85;
        #1;
        chk("fetch drop", 32'(drop), 32'd1);
        @(posedge clk);
        #1;
        wr = 1'b0;
        #1;
        chk("fetch drop one clk", 32'(drop), 32'd0);
        issue_check("start p3", 4'b0100, 4'b0000, 1'b0);
        chk("p3 start_addr", 32'(start_addr), 32'h31234);
        chk("p3 stop_addr", 32'(stop_addr), 32'h15678);
        chk("p3 att", 32'(att), 32'hA);

        // Reset during byte 3 of a fetch.
        rom_delay = 3;
        wr_cmd(8'h85);
        wr_cmd(8'h12);
        hit = 1'b0;
        guard = 0;
        while (!hit && guard < 200) begin
            @(negedge clk);
            guard = guard + 1;
            if (rom_cs && rom_addr[2:0] == 3'd3) hit = 1'b1;
        end
        chk("reach byte3", 32'(hit), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst rom_cs", 32'(rom_cs), 32'd0);
        chk("midrst outputs", {start, stop, att, 3'd0, ctrl_busy, drop}, 32'd0);
        chk("midrst stop_addr", 32'(stop_addr), 32'd0);
        chk("midrst start_addr", 32'(start_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rom_delay = 1;
        wr_cmd(8'h83);
        wr_cmd(8'h4A);
        issue_check("post rst p3", 4'b0100, 4'b0000, 1'b0);
        chk("post rst start_addr", 32'(start_addr), 32'h31234);
        chk("post rst stop_addr", 32'(stop_addr), 32'h15678);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
